// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types, constants and helpers for cpu_axi_bridge.
//   - bridge_state_e : per-port FSM state encoding (IDLE, AR, R, WR, B)
//   - AXI burst/length/size constants for single-beat INCR transfers
//   - wen_to_size()  : byte-enable pattern -> AXI AxSIZE
//   - kseg_map()     : fixed kseg0/kseg1 -> physical address mapping
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4
  } bridge_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  // Irregular strobe patterns fall back to a word-sized beat; wstrb still
  // selects the bytes actually written.
  function automatic logic [2:0] wen_to_size(input logic [3:0] wen);
    logic [2:0] size;
    case (wen)
      4'b1111:                            size = AXI_SIZE_WORD;
      4'b0011, 4'b1100:                   size = AXI_SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = AXI_SIZE_BYTE;
      default:                            size = AXI_SIZE_WORD;
    endcase
    return size;
  endfunction

  // kseg0 (3'b100) and kseg1 (3'b101) both alias the low 512 MB.
  function automatic logic [31:0] kseg_map(input logic [31:0] addr);
    logic [31:0] mapped;
    if (addr[31:29] == 3'b100 || addr[31:29] == 3'b101) begin
      mapped = {3'b000, addr[28:0]};
    end else begin
      mapped = addr;
    end
    return mapped;
  endfunction

endpackage

// File: rtl/bridge_port_ctrl.sv
// bridge_port_ctrl: completion tracking for one SRAM-like core port.
// Holds the done flag and the returned-data register, and derives the
// stall seen by the core.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              core request held on this port
//   longest_stall   pipeline frozen this cycle (keeps done alive)
//   resp_fire       the response that completes this port's request
//   rdata_load      load rdata_in into the data register
//   rdata_in        read data from the R channel
//   done            request has completed, result held
//   stall           request outstanding (en & ~done), 0 during reset
//   rdata           registered read data
module bridge_port_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        longest_stall,
  input  logic        resp_fire,
  input  logic        rdata_load,
  input  logic [31:0] rdata_in,
  output logic        done,
  output logic        stall,
  output logic [31:0] rdata
);

  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  // A response always sets done, even when the pipeline advances in the
  // same cycle; done then drops the first cycle longest_stall is low.
  always_comb begin
    done_d  = resp_fire | (done_q & longest_stall);
    rdata_d = rdata_q;
    if (rdata_load) begin
      rdata_d = rdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done  = done_q;
  assign stall = en & ~done_q & ~rst;
  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: connects the MIPS core's SRAM-like instruction and data
// ports to one AXI4 master. Each held request becomes a single-beat AXI
// read or write; the port stalls until the response fires and the result
// is held until the pipeline advances (longest_stall low).
//
// Optional feature: define BRIDGE_ADDR_MAP_EN to map kseg0/kseg1 addresses
// to physical (addr[31:29] of 100/101 -> 000) on AR and AW.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   inst_sram_*  / inst_stall      instruction fetch port
//   data_sram_*  / data_stall      data port (wen != 0 means write)
//   longest_stall                  pipeline frozen this cycle
//   ar*, r*, aw*, w*, b*           AXI4 master channels (single beat)
//   inst_state_dbg, data_state_dbg per-port FSM state
//
// Handshake: a transfer on any AXI channel happens in a cycle where both
// valid and ready are high; a valid, once raised, holds its payload stable
// and stays high until that transfer. rready and bready are tied high.
module cpu_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic          clk,
  input  logic          rst,
  // instruction port
  input  logic          inst_sram_en,
  input  logic [31:0]   inst_sram_addr,
  output logic [31:0]   inst_sram_rdata,
  output logic          inst_stall,
  // data port
  input  logic          data_sram_en,
  input  logic [31:0]   data_sram_addr,
  input  logic [3:0]    data_sram_wen,
  input  logic [31:0]   data_sram_wdata,
  output logic [31:0]   data_sram_rdata,
  output logic          data_stall,
  input  logic          longest_stall,
  // AR channel
  output logic [3:0]    arid,
  output logic [31:0]   araddr,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic          arvalid,
  input  logic          arready,
  // R channel
  input  logic [3:0]    rid,
  input  logic [31:0]   rdata,
  input  logic          rvalid,
  output logic          rready,
  // AW channel
  output logic [3:0]    awid,
  output logic [31:0]   awaddr,
  output logic [7:0]    awlen,
  output logic [2:0]    awsize,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  // W channel
  output logic [31:0]   wdata,
  output logic [3:0]    wstrb,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  // B channel
  input  logic          bvalid,
  output logic          bready,
  // debug
  output bridge_state_e inst_state_dbg,
  output bridge_state_e data_state_dbg
);

  bridge_state_e inst_state_q, inst_state_d;
  bridge_state_e data_state_q, data_state_d;

  logic ar_lock_q, ar_lock_d;     // AR offered but not yet accepted
  logic ar_owner_q, ar_owner_d;   // 1 = data port owns the locked AR
  logic aw_sent_q, aw_sent_d;
  logic w_sent_q, w_sent_d;

  logic inst_done, data_done;
  logic inst_in_ar, data_in_ar, ar_sel_data, ar_fire;
  logic inst_ar_fire, data_ar_fire;
  logic inst_r_fire, data_r_fire, data_b_fire;
  logic aw_ok, w_ok;
  logic [31:0] ar_addr_aligned;
  logic unused_inst_lsb;

  // ---------------------------------------------------------------------
  // AR arbitration: data wins a fresh contest; once offered, the winner is
  // held until accepted so the AR payload never changes under arvalid.
  // ---------------------------------------------------------------------
  assign inst_in_ar  = (inst_state_q == ST_AR);
  assign data_in_ar  = (data_state_q == ST_AR);
  assign ar_sel_data = ar_lock_q ? ar_owner_q : data_in_ar;
  assign arvalid     = inst_in_ar | data_in_ar;
  assign ar_fire     = arvalid & arready;
  assign inst_ar_fire = ar_fire & ~ar_sel_data;
  assign data_ar_fire = ar_fire & ar_sel_data;

  always_comb begin
    ar_lock_d  = arvalid & ~arready;
    ar_owner_d = ar_sel_data;
  end

  assign arid            = ar_sel_data ? DATA_ID : INST_ID;
  assign ar_addr_aligned = ar_sel_data ? {data_sram_addr[31:2], 2'b00}
                                       : {inst_sram_addr[31:2], 2'b00};
  assign unused_inst_lsb = ^inst_sram_addr[1:0];

`ifdef BRIDGE_ADDR_MAP_EN
  assign araddr = kseg_map(ar_addr_aligned);
  assign awaddr = kseg_map(data_sram_addr);
`else
  assign araddr = ar_addr_aligned;
  assign awaddr = data_sram_addr;
`endif

  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  // Responses only count in the state that expects them; anything else
  // (e.g. a late beat after reset) is dropped.
  assign rready      = 1'b1;
  assign bready      = 1'b1;
  assign inst_r_fire = (inst_state_q == ST_R) & rvalid & (rid == INST_ID);
  assign data_r_fire = (data_state_q == ST_R) & rvalid & (rid == DATA_ID);
  assign data_b_fire = (data_state_q == ST_B) & bvalid;

  // ---------------------------------------------------------------------
  // Write channels: AW and W are offered together and each drops after
  // its own handshake.
  // ---------------------------------------------------------------------
  assign awid    = DATA_ID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = wen_to_size(data_sram_wen);
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (data_state_q == ST_WR) & ~aw_sent_q;
  assign wvalid  = (data_state_q == ST_WR) & ~w_sent_q;
  assign wdata   = data_sram_wdata;
  assign wstrb   = data_sram_wen;
  assign wlast   = 1'b1;

  assign aw_ok = aw_sent_q | (awvalid & awready);
  assign w_ok  = w_sent_q  | (wvalid & wready);

  always_comb begin
    aw_sent_d = 1'b0;
    w_sent_d  = 1'b0;
    if (data_state_q == ST_WR && !(aw_ok && w_ok)) begin
      aw_sent_d = aw_ok;
      w_sent_d  = w_ok;
    end
  end

  // ---------------------------------------------------------------------
  // Instruction port FSM
  // ---------------------------------------------------------------------
  always_comb begin
    inst_state_d = inst_state_q;
    case (inst_state_q)
      ST_IDLE: if (inst_sram_en && !inst_done) inst_state_d = ST_AR;
      ST_AR:   if (inst_ar_fire)               inst_state_d = ST_R;
      ST_R:    if (inst_r_fire)                inst_state_d = ST_IDLE;
      default:                                 inst_state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Data port FSM
  // ---------------------------------------------------------------------
  always_comb begin
    data_state_d = data_state_q;
    case (data_state_q)
      ST_IDLE: begin
        if (data_sram_en && !data_done) begin
          data_state_d = (data_sram_wen == 4'b0000) ? ST_AR : ST_WR;
        end
      end
      ST_AR:   if (data_ar_fire)   data_state_d = ST_R;
      ST_R:    if (data_r_fire)    data_state_d = ST_IDLE;
      ST_WR:   if (aw_ok && w_ok)  data_state_d = ST_B;
      ST_B:    if (data_b_fire)    data_state_d = ST_IDLE;
      default:                     data_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_state_q <= ST_IDLE;
      data_state_q <= ST_IDLE;
      ar_lock_q    <= 1'b0;
      ar_owner_q   <= 1'b0;
      aw_sent_q    <= 1'b0;
      w_sent_q     <= 1'b0;
    end else begin
      inst_state_q <= inst_state_d;
      data_state_q <= data_state_d;
      ar_lock_q    <= ar_lock_d;
      ar_owner_q   <= ar_owner_d;
      aw_sent_q    <= aw_sent_d;
      w_sent_q     <= w_sent_d;
    end
  end

  assign inst_state_dbg = inst_state_q;
  assign data_state_dbg = data_state_q;

  // ---------------------------------------------------------------------
  // Per-port completion / result holding
  // ---------------------------------------------------------------------
  bridge_port_ctrl u_inst_port (
    .clk           (clk),
    .rst           (rst),
    .en            (inst_sram_en),
    .longest_stall (longest_stall),
    .resp_fire     (inst_r_fire),
    .rdata_load    (inst_r_fire),
    .rdata_in      (rdata),
    .done          (inst_done),
    .stall         (inst_stall),
    .rdata         (inst_sram_rdata)
  );

  bridge_port_ctrl u_data_port (
    .clk           (clk),
    .rst           (rst),
    .en            (data_sram_en),
    .longest_stall (longest_stall),
    .resp_fire     (data_r_fire | data_b_fire),
    .rdata_load    (data_r_fire),
    .rdata_in      (rdata),
    .done          (data_done),
    .stall         (data_stall),
    .rdata         (data_sram_rdata)
  );

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Bridge between the MIPS core's SRAM-like instruction and data ports and a single AXI4 master interface. It owns the response side of the core's request/stall protocol. It converts held requests into AXI read and write transactions and drives `inst_stall` and `data_stall` until each request completes. Completed results are held until the whole pipeline advances, which is signalled by `longest_stall` going low.

## Interface
Parameters:
- `INST_ID`, 4'd0: ARID used for instruction fetches.
- `DATA_ID`, 4'd1: ARID and AWID used for data accesses.

Ports:
- `clk`  in  1  single clock; all logic rises on it.
- `rst`  in  1  synchronous, active-high reset.
- `inst_sram_en` in 1, `inst_sram_addr` in 32: instruction fetch request, held while stalled.
- `inst_sram_rdata`  out  32  fetched word.
- `inst_stall`  out  1  instruction request not yet complete.
- `data_sram_en` in 1, `data_sram_addr` in 32, `data_sram_wen` in 4, `data_sram_wdata` in 32: data request. `wen != 0` means write.
- `data_sram_rdata`  out  32  loaded word.
- `data_stall`  out  1  data request not yet complete.
- `longest_stall`  in  1  pipeline frozen this cycle.
- `arid` out 4, `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1: AR channel.
- `arlen` out 8 and `awlen` out 8 are constant 0; `arburst` out 2 and `awburst` out 2 are constant 01.
- `rid` in 4, `rdata` in 32, `rvalid` in 1, `rready` out 1 (constant 1): R channel. `rresp` and `rlast` are ignored.
- `awid` out 4, `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1: AW channel.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1 (constant 1), `wvalid` out 1, `wready` in 1: W channel.
- `bvalid` in 1, `bready` out 1 (constant 1): B channel. `bid` and `bresp` are ignored.

## Operation
Each port has a `done` flag and an rdata register.
- `stall = en & ~done`, forced to 0 while `rst` is high.
- The `done` flag updates as follows:
  - `done_next = 1` on the response fire for that port.
  - Otherwise `done_next = done & longest_stall`.
- The data port's rdata register loads on an R fire where `rid == DATA_ID`. It holds until the next load.
- The instruction port's rdata register follows the same rule with `INST_ID`.

Instruction port FSM:
- IDLE -> AR when `en & ~done`.
- AR -> R on `arvalid & arready`.
- R -> IDLE on `rvalid & rid == INST_ID`; this sets `done`.

Data port FSM:
- IDLE -> AR when `en & ~done & wen == 0`.
- IDLE -> WR when `en & ~done & wen != 0`.
- AR -> R on AR fire.
- R -> IDLE on `rvalid & rid == DATA_ID`; this sets `done`.
- WR -> B once both AW and W have fired. They may fire in the same cycle or in either order; per-channel "sent" flags drop each valid after its own handshake.
- B -> IDLE on `bvalid`; this sets `done`.

AR arbitration:
- One shared AR channel. When both ports are in AR, data wins.
- The winner is latched while `arvalid` is high; the AR signals stay stable until `arready`.
- Both reads may be outstanding at once; responses are routed by `rid`.

Address and size rules:
- Reads: `araddr = {addr[31:2], 2'b00}`, `arsize = 3'd2`.
- Writes: `awaddr = addr`, `wstrb = wen`, `wdata = data_sram_wdata`.
- `awsize` from `wen`:
  - 4'b1111 -> 2.
  - 4'b0011 or 4'b1100 -> 1.
  - One-hot -> 0.
  - Any other value -> 2.

Reset:
- All FSMs return to IDLE and all `done` flags clear.
- `arvalid`, `awvalid`, `wvalid` = 0; `inst_stall` and `data_stall` = 0.
- rdata registers = 32'h0.
- A reset mid-transaction abandons it. Any late R or B response is discarded, because no FSM is in R or B.

## Timing
- Minimum latency: the request is seen in IDLE, AR issues in cycle 1, R returns in cycle 2 at the earliest, and stall drops in cycle 3. Stall therefore drops one cycle after the response fire, and rdata is registered.
- The `done` flag clears the first cycle `longest_stall` is low. A new request is accepted (IDLE -> AR/WR) the cycle after that.
- When `done` is set and `longest_stall` is low in the same cycle, `done` still sets. It clears the following cycle.
- While `done` is set, the held request is never reissued, even if the other port keeps the pipeline frozen.
- A response arriving while the port is not in R or B is dropped.

## Configuration
- `BRIDGE_ADDR_MAP_EN` defined: AXI addresses get fixed kseg mapping. `addr[31:29]` of 3'b100 or 3'b101 is replaced with 3'b000; other addresses pass unchanged.
- Undefined: addresses pass through unmodified.

## Structure
- Package `bridge_pkg` holds:
  - The FSM state encodings (IDLE, AR, R, WR, B).
  - The AXI burst and size constants.
  - The `wen` -> size function.
  - The kseg mapping function.
- Sub-module `bridge_port_ctrl` holds the `done` flag, the rdata register and the stall logic. It is instantiated once per port.

## Test plan
- Fetch at 32'hBFC00000, `arready` and `rvalid` answered after 1 cycle -> `araddr = 32'h1FC00000` with mapping (32'hBFC00000 without), `inst_stall` high 3 cycles, `inst_sram_rdata = rdata`.
- Simultaneous fetch and load in IDLE -> first AR carries `arid = 1`, second `arid = 0`. Out-of-order R (`rid` 0 then 1) routed to the correct ports.
- `sb` with `wen = 4'b0100`, addr 32'h80000002 -> `awsize = 0`, `wstrb = 4'b0100`. `awready` 2 cycles before `wready` -> each valid drops after its own handshake, and `data_stall` drops the cycle after `bvalid`.
- Instruction done while the data port stalls for 10 more cycles, with `longest_stall` held high -> exactly one AR for the fetch and `inst_sram_rdata` stable throughout.
- Assert `rst` while in R, then `rvalid` arrives -> response ignored, outputs at reset values, no `done` flag set.
